// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-requester writeback arbiter for a single register-file
//               write port. Each requester owns a one-entry buffer; grants are
//               round-robin except that same-register writes retire in age
//               order. Also answers read-operand hazard queries.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  // requester A (ALU writeback)
  input  logic        A_Valid,
  output logic        A_Ready,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  // requester B (load writeback)
  input  logic        B_Valid,
  output logic        B_Ready,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  // register-file write port
  output logic        RegWrite,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Write_Data,
  // hazard query
  input  logic [4:0]  Read_Reg1,
  input  logic [4:0]  Read_Reg2,
  output logic        Stall
);

  logic        a_full_q, a_full_d;
  logic [4:0]  a_reg_q,  a_reg_d;
  logic [31:0] a_data_q, a_data_d;
  logic        b_full_q, b_full_d;
  logic [4:0]  b_reg_q,  b_reg_d;
  logic [31:0] b_data_q, b_data_d;
  logic        wr_en_q,  wr_en_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [31:0] wr_data_q, wr_data_d;
  // ptr_q = 0 favours A, 1 favours B; age_q = 0 means A is older, 1 means B
  logic        ptr_q, ptr_d;
  logic        age_q, age_d;

  logic        a_load, b_load;
  logic        grant_a, grant_b;

  assign A_Ready    = ~a_full_q;
  assign B_Ready    = ~b_full_q;
  assign RegWrite   = wr_en_q;
  assign Write_Reg  = wr_reg_q;
  assign Write_Data = wr_data_q;

  // Accept / grant decision; register 0 writes are swallowed at the door
  always_comb begin
    a_load  = A_Valid && !a_full_q && (A_Reg != 5'd0);
    b_load  = B_Valid && !b_full_q && (B_Reg != 5'd0);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_reg_q == b_reg_q) begin
        grant_a = ~age_q;
        grant_b = age_q;
      end else begin
        grant_a = ~ptr_q;
        grant_b = ptr_q;
      end
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  // Next-state for buffers, write port, pointer and age bit
  always_comb begin
    a_full_d  = a_full_q;
    a_reg_d   = a_reg_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_reg_d   = b_reg_q;
    b_data_d  = b_data_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    age_d     = age_q;

    if (grant_a) begin
      a_full_d  = 1'b0;
      wr_en_d   = 1'b1;
      wr_reg_d  = a_reg_q;
      wr_data_d = a_data_q;
      ptr_d     = 1'b1;
    end else if (grant_b) begin
      b_full_d  = 1'b0;
      wr_en_d   = 1'b1;
      wr_reg_d  = b_reg_q;
      wr_data_d = b_data_q;
      ptr_d     = 1'b0;
    end

    // Loading only happens into an empty buffer, so never collides with its grant
    if (a_load) begin
      a_full_d = 1'b1;
      a_reg_d  = A_Reg;
      a_data_d = A_Data;
    end
    if (b_load) begin
      b_full_d = 1'b1;
      b_reg_d  = B_Reg;
      b_data_d = B_Data;
    end

    // Simultaneous loads make A the elder; otherwise the resident entry is elder
    if (a_load && b_load) begin
      age_d = 1'b0;
    end else if (a_load && b_full_q) begin
      age_d = 1'b1;
    end else if (b_load && a_full_q) begin
      age_d = 1'b0;
    end
  end

  // State registers with asynchronous reset dropping all pending writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full_q  <= 1'b0;
      a_reg_q   <= 5'd0;
      a_data_q  <= 32'd0;
      b_full_q  <= 1'b0;
      b_reg_q   <= 5'd0;
      b_data_q  <= 32'd0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
      ptr_q     <= 1'b0;
      age_q     <= 1'b0;
    end else begin
      a_full_q  <= a_full_d;
      a_reg_q   <= a_reg_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_reg_q   <= b_reg_d;
      b_data_q  <= b_data_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      age_q     <= age_d;
    end
  end

  function automatic logic pending(input logic [4:0] r);
    pending = (r != 5'd0) &&
              ((a_full_q && (a_reg_q == r)) ||
               (b_full_q && (b_reg_q == r)) ||
               (wr_en_q  && (wr_reg_q == r)));
  endfunction

  // Hazard query covers both buffers and the write currently on the port
  always_comb begin
    Stall = pending(Read_Reg1) | pending(Read_Reg2);
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        A_Valid, B_Valid;
  logic        A_Ready, B_Ready;
  logic [4:0]  A_Reg, B_Reg;
  logic [31:0] A_Data, B_Data;
  logic        RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Reg1, Read_Reg2;
  logic        Stall;

  int n_vec;
  int n_err;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .A_Valid    (A_Valid),
    .A_Ready    (A_Ready),
    .A_Reg      (A_Reg),
    .A_Data     (A_Data),
    .B_Valid    (B_Valid),
    .B_Ready    (B_Ready),
    .B_Reg      (B_Reg),
    .B_Data     (B_Data),
    .RegWrite   (RegWrite),
    .Write_Reg  (Write_Reg),
    .Write_Data (Write_Data),
    .Read_Reg1  (Read_Reg1),
    .Read_Reg2  (Read_Reg2),
    .Stall      (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] a_seq [3];
    logic [4:0] b_seq [3];
    logic [4:0] wr_seen [6];
    logic [4:0] exp_order [6];
    int ai, bi, nw, first_cyc, last_cyc;
    logic a_fire, b_fire;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    A_Valid = 1'b0; A_Reg = 5'd0; A_Data = 32'd0;
    B_Valid = 1'b0; B_Reg = 5'd0; B_Data = 32'd0;
    Read_Reg1 = 5'd0; Read_Reg2 = 5'd0;

    // reset state
    #1;
    check_val("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_val("rst_a_ready", {31'd0, A_Ready}, 32'd1);
    check_val("rst_b_ready", {31'd0, B_Ready}, 32'd1);
    check_val("rst_stall", {31'd0, Stall}, 32'd0);
    check_val("rst_write_reg", {27'd0, Write_Reg}, 32'd0);
    check_val("rst_write_data", Write_Data, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // single write
    A_Valid = 1'b1; A_Reg = 5'd5; A_Data = 32'h1234;
    tick();
    A_Valid = 1'b0;
    check_val("single_a_ready_busy", {31'd0, A_Ready}, 32'd0);
    check_val("single_no_early_write", {31'd0, RegWrite}, 32'd0);
    tick();
    check_val("single_regwrite", {31'd0, RegWrite}, 32'd1);
    check_val("single_write_reg", {27'd0, Write_Reg}, 32'd5);
    check_val("single_write_data", Write_Data, 32'h1234);
    check_val("single_a_ready_free", {31'd0, A_Ready}, 32'd1);
    tick();
    check_val("single_regwrite_drop", {31'd0, RegWrite}, 32'd0);
    check_val("single_hold_reg", {27'd0, Write_Reg}, 32'd5);
    check_val("single_hold_data", Write_Data, 32'h1234);

    // register 0 is swallowed
    A_Valid = 1'b1; A_Reg = 5'd0; A_Data = 32'hFFFF;
    tick();
    A_Valid = 1'b0;
    check_val("r0_a_ready", {31'd0, A_Ready}, 32'd1);
    check_val("r0_stall", {31'd0, Stall}, 32'd0);
    tick();
    check_val("r0_no_write", {31'd0, RegWrite}, 32'd0);
    check_val("r0_data_held", Write_Data, 32'h1234);

    // hazard through Read_Reg1
    Read_Reg1 = 5'd4; Read_Reg2 = 5'd8;
    #1;
    check_val("haz_idle_stall", {31'd0, Stall}, 32'd0);
    A_Valid = 1'b1; A_Reg = 5'd4; A_Data = 32'h44;
    tick();
    A_Valid = 1'b0;
    check_val("haz_stall_buffered", {31'd0, Stall}, 32'd1);
    tick();
    check_val("haz_regwrite", {31'd0, RegWrite}, 32'd1);
    check_val("haz_stall_writing", {31'd0, Stall}, 32'd1);
    tick();
    check_val("haz_stall_clear", {31'd0, Stall}, 32'd0);

    // hazard through Read_Reg2 on a B write (leaves pointer favouring A)
    Read_Reg1 = 5'd0; Read_Reg2 = 5'd8;
    B_Valid = 1'b1; B_Reg = 5'd8; B_Data = 32'h88;
    tick();
    B_Valid = 1'b0;
    check_val("hazb_b_ready", {31'd0, B_Ready}, 32'd0);
    check_val("hazb_stall", {31'd0, Stall}, 32'd1);
    tick();
    check_val("hazb_write_reg", {27'd0, Write_Reg}, 32'd8);
    check_val("hazb_write_data", Write_Data, 32'h88);
    tick();
    check_val("hazb_stall_clear", {31'd0, Stall}, 32'd0);
    Read_Reg2 = 5'd0;

    // same register: B first, then A one edge later
    B_Valid = 1'b1; B_Reg = 5'd7; B_Data = 32'hB;
    tick();
    B_Valid = 1'b0;
    A_Valid = 1'b1; A_Reg = 5'd7; A_Data = 32'hA;
    tick();
    A_Valid = 1'b0;
    check_val("same_first_data", Write_Data, 32'hB);
    check_val("same_first_we", {31'd0, RegWrite}, 32'd1);
    tick();
    check_val("same_second_data", Write_Data, 32'hA);
    check_val("same_second_we", {31'd0, RegWrite}, 32'd1);
    tick();
    check_val("same_final_data", Write_Data, 32'hA);
    check_val("same_final_we", {31'd0, RegWrite}, 32'd0);

    // same register on the same edge while pointer favours B: A is older
    A_Valid = 1'b1; A_Reg = 5'd7; A_Data = 32'hA1;
    B_Valid = 1'b1; B_Reg = 5'd7; B_Data = 32'hB1;
    tick();
    A_Valid = 1'b0; B_Valid = 1'b0;
    tick();
    check_val("age_first_data", Write_Data, 32'hA1);
    tick();
    check_val("age_second_data", Write_Data, 32'hB1);
    tick();
    check_val("age_idle_we", {31'd0, RegWrite}, 32'd0);

    // round-robin streaming
    a_seq = '{5'd1, 5'd2, 5'd3};
    b_seq = '{5'd9, 5'd10, 5'd11};
    exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    wr_seen = '{default: 5'd0};
    ai = 0; bi = 0; nw = 0; first_cyc = -1; last_cyc = -1;
    A_Valid = 1'b1; A_Reg = a_seq[0]; A_Data = 32'hA001;
    B_Valid = 1'b1; B_Reg = b_seq[0]; B_Data = 32'hB009;
    for (int cyc = 0; cyc < 30 && nw < 6; cyc++) begin
      a_fire = A_Valid && A_Ready;
      b_fire = B_Valid && B_Ready;
      tick();
      if (a_fire) begin
        ai++;
        if (ai < 3) begin
          A_Reg = a_seq[ai];
          A_Data = 32'hA000 + {27'd0, a_seq[ai]};
        end else begin
          A_Valid = 1'b0;
        end
      end
      if (b_fire) begin
        bi++;
        if (bi < 3) begin
          B_Reg = b_seq[bi];
          B_Data = 32'hB000 + {27'd0, b_seq[bi]};
        end else begin
          B_Valid = 1'b0;
        end
      end
      if (RegWrite) begin
        wr_seen[nw] = Write_Reg;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nw++;
      end
    end
    A_Valid = 1'b0; B_Valid = 1'b0;
    check_val("rr_write_count", nw, 32'd6);
    check_val("rr_back_to_back", last_cyc - first_cyc, 32'd5);
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("rr_order_%0d", k), {27'd0, wr_seen[k]}, {27'd0, exp_order[k]});
    end
    check_val("rr_last_data", Write_Data, 32'hB00B);
    tick();

    // reset mid-flight with both buffers occupied
    A_Valid = 1'b1; A_Reg = 5'd12; A_Data = 32'hC;
    B_Valid = 1'b1; B_Reg = 5'd13; B_Data = 32'hD;
    tick();
    A_Valid = 1'b0; B_Valid = 1'b0;
    tick();
    check_val("mid_regwrite_before", {31'd0, RegWrite}, 32'd1);
    check_val("mid_b_ready_before", {31'd0, B_Ready}, 32'd0);
    Read_Reg1 = 5'd13; Read_Reg2 = 5'd12;
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_regwrite_async", {31'd0, RegWrite}, 32'd0);
    check_val("mid_a_ready", {31'd0, A_Ready}, 32'd1);
    check_val("mid_b_ready", {31'd0, B_Ready}, 32'd1);
    check_val("mid_stall", {31'd0, Stall}, 32'd0);
    A_Valid = 1'b1; A_Reg = 5'd3; A_Data = 32'h3;
    tick();
    check_val("rst_no_transfer", {31'd0, A_Ready}, 32'd1);
    rst = 1'b0;
    A_Valid = 1'b0;
    tick();
    check_val("post_rst_we0", {31'd0, RegWrite}, 32'd0);
    tick();
    check_val("post_rst_we1", {31'd0, RegWrite}, 32'd0);
    check_val("post_rst_stall", {31'd0, Stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
